// File: rtl/seg_pkg.sv
// Shared constants, state encoding and code-legality helper for the 7-seg scan controller.
package seg_pkg;

  localparam logic [3:0] CODE_BLANK = 4'd0;
  localparam logic [3:0] CODE_MIN   = 4'd3;
  localparam logic [3:0] CODE_MAX   = 4'd12;

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } seg_state_e;

  // Code 0 is the intentional blank; every other code outside 3..12 is an error.
  function automatic logic code_is_err(input logic [3:0] code);
    return (code != CODE_BLANK) && ((code < CODE_MIN) || (code > CODE_MAX));
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot timebase: cycle counter within a slot, digit index, and slot/frame strobes.
module seg_slot_timer
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned SLOT_CYC  = 100000,
  parameter int unsigned BLANK_CYC = 16,
  localparam int unsigned IdxW     = $clog2(N_DIGITS),
  localparam int unsigned CntW     = $clog2(SLOT_CYC)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [IdxW-1:0] idx_o,
  output logic            show_start_o,
  output logic            slot_end_o,
  output logic            frame_end_o
);

  localparam logic [CntW-1:0] CntLast      = CntW'(SLOT_CYC - 1);
  localparam logic [CntW-1:0] CntBlankLast = CntW'(BLANK_CYC - 1);
  localparam logic [IdxW-1:0] IdxLast      = IdxW'(N_DIGITS - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            slot_end;

  always_comb begin
    slot_end = (cnt_q == CntLast);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx_o        = idx_q;
  assign slot_end_o   = slot_end;
  // Last blank cycle of the slot: the FSM enters SHOW on the following edge.
  assign show_start_o = (cnt_q == CntBlankLast);
  assign frame_end_o  = slot_end && (idx_q == IdxLast);

endmodule

// File: rtl/seg_scan_controller.sv
// Multiplexed common-anode 7-seg scanner: blank/show FSM, tear-free double-buffered display
// word with ready/valid write port, registered anode and decoder-code outputs.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned SLOT_CYC  = 100000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [4*N_DIGITS-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  blank_all,
  output logic [3:0]            code_out,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done,
  output logic                  code_err
);

  localparam int unsigned IdxW = $clog2(N_DIGITS);

  logic [IdxW-1:0] idx;
  logic            show_start, slot_end, frame_end;

  seg_slot_timer #(
    .N_DIGITS (N_DIGITS),
    .SLOT_CYC (SLOT_CYC),
    .BLANK_CYC(BLANK_CYC)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .idx_o       (idx),
    .show_start_o(show_start),
    .slot_end_o  (slot_end),
    .frame_end_o (frame_end)
  );

  seg_state_e state_q, state_d;

  logic [4*N_DIGITS-1:0] pend_q, pend_d;
  logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [3:0]            code_q, code_d;
  logic                  fd_q, fd_d;
  logic                  wr_accept;
  logic [3:0]            digit_code;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BLANK: if (show_start) state_d = ST_SHOW;
      ST_SHOW:  if (slot_end)   state_d = ST_BLANK;
      default:                  state_d = ST_BLANK;
    endcase
  end

  // ready_q doubles as "pending empty", so a write and a commit never coincide.
  always_comb begin
    wr_accept = wr_valid && ready_q;
    pend_d    = pend_q;
    shadow_d  = shadow_q;
    ready_d   = ready_q;
    err_d     = err_q;
    if (wr_accept) begin
      pend_d  = wr_data;
      ready_d = 1'b0;
      for (int k = 0; k < N_DIGITS; k++) begin
        if (code_is_err(wr_data[4*k +: 4])) err_d = 1'b1;
      end
    end
    if (frame_end && !ready_q) begin
      shadow_d = pend_q;
      ready_d  = 1'b1;
    end
  end

  always_comb begin
    digit_code = shadow_q[{idx, 2'b00} +: 4];
    an_d       = '1;
    code_d     = CODE_BLANK;
    if (state_q == ST_SHOW) begin
      code_d = digit_code;
      if (!blank_all) an_d[idx] = 1'b0;
    end
    fd_d = frame_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BLANK;
      pend_q   <= '0;
      shadow_q <= '0;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
      an_q     <= '1;
      code_q   <= CODE_BLANK;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      an_q     <= an_d;
      code_q   <= code_d;
      fd_q     <= fd_d;
    end
  end

  assign wr_ready   = ready_q;
  assign code_err   = err_q;
  assign an         = an_q;
  assign code_out   = code_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench: stimulus queues expected per-digit show windows, a monitor checks each one.
module tb_seg_scan_controller;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        wr_valid  = 1'b0;
  logic [15:0] wr_data   = '0;
  logic        blank_all = 1'b0;
  logic        wr_ready;
  logic [3:0]  code_out;
  logic [3:0]  an;
  logic        frame_done;
  logic        code_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_fd = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] code;
  } win_t;

  win_t exp_q[$];

  seg_scan_controller #(
    .N_DIGITS (4),
    .SLOT_CYC (8),
    .BLANK_CYC(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .blank_all (blank_all),
    .code_out  (code_out),
    .an        (an),
    .frame_done(frame_done),
    .code_err  (code_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One expected show window per digit, in scan order.
  task automatic push_frame(input logic [15:0] word);
    for (int k = 0; k < 4; k++) begin
      win_t w;
      w.an    = 4'hF;
      w.an[k] = 1'b0;
      w.code  = word[4*k +: 4];
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: got no pulse expected pulse within 100 cycles");
    end else begin
      check("frame_period", cyc - last_fd, 32);
    end
    last_fd = cyc;
  endtask

  // Monitor: a window opens when any anode goes low; it must match the queue head for its
  // whole length and last exactly SLOT_CYC-BLANK_CYC cycles.
  bit   in_win  = 1'b0;
  bit   tracked = 1'b0;
  int   win_len = 0;
  win_t cur;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_win  = 1'b0;
        tracked = 1'b0;
      end else if (an != 4'hF) begin
        if (!in_win) begin
          in_win  = 1'b1;
          win_len = 0;
          tracked = 1'b0;
          if (mon_en) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_window: got an=%b code=%0d expected none", an, code_out);
            end else begin
              cur     = exp_q.pop_front();
              tracked = 1'b1;
            end
          end
        end
        win_len++;
        if (tracked) check("window_an_code", {24'd0, an, code_out}, {24'd0, cur.an, cur.code});
      end else if (in_win) begin
        in_win = 1'b0;
        if (tracked) check("window_len", win_len, 6);
        tracked = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by t=100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cycles(3);
    check("rst_an", an, 4'hF);
    check("rst_code_out", code_out, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_frame_done", frame_done, 0);
    check("rst_code_err", code_err, 0);

    // Frame 0: idle, shadow blank.
    rst_n   = 1'b1;
    last_fd = cyc;
    mon_en  = 1'b1;
    push_frame(16'h0000);
    cycles(5);
    wr_valid = 1'b1;
    wr_data  = 16'hC953;
    cycles(1);
    check("wr_ready_after_write", wr_ready, 0);
    wr_valid = 1'b0;
    cycles(4);
    wr_valid = 1'b1;
    wr_data  = 16'h4444;
    cycles(2);
    check("wr_ready_while_full", wr_ready, 0);
    wr_valid = 1'b0;

    wait_frame();
    check("wr_ready_after_commit", wr_ready, 1);
    push_frame(16'hC953);

    wait_frame();
    check("code_err_legal", code_err, 0);
    push_frame(16'hC953);
    cycles(5);
    wr_valid = 1'b1;
    wr_data  = 16'h0F33;
    cycles(1);
    check("code_err_set", code_err, 1);
    check("wr_ready_illegal_write", wr_ready, 0);
    wr_valid = 1'b0;

    wait_frame();
    check("wr_ready_commit2", wr_ready, 1);
    check("code_err_sticky", code_err, 1);
    push_frame(16'h0F33);

    // Frame 4: blank_all for 20 cycles starting at the edge that ends slot 0.
    wait_frame();
    mon_en = 1'b0;
    cycles(8);
    blank_all = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cycles(1);
      check("blank_all_an", an, 4'hF);
      if (i == 4)  check("blank_all_code_d1", code_out, 3);
      if (i == 12) check("blank_all_code_d2", code_out, 15);
    end
    blank_all = 1'b0;

    wait_frame();
    mon_en = 1'b1;
    push_frame(16'h0F33);

    // Frame 6: fill pending, then reset during digit 2 show.
    wait_frame();
    mon_en = 1'b0;
    cycles(5);
    wr_valid = 1'b1;
    wr_data  = 16'h7777;
    cycles(1);
    wr_valid = 1'b0;
    cycles(14);
    check("pre_rst_an", an, 4'b1011);
    check("pre_rst_code", code_out, 15);
    check("pre_rst_wr_ready", wr_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_an", an, 4'hF);
    check("mid_rst_code", code_out, 0);
    check("mid_rst_wr_ready", wr_ready, 1);
    check("mid_rst_code_err", code_err, 0);
    check("mid_rst_frame_done", frame_done, 0);
    cycles(1);
    rst_n   = 1'b1;
    last_fd = cyc;
    mon_en  = 1'b1;
    push_frame(16'h0000);

    wait_frame();
    check("post_rst_wr_ready", wr_ready, 1);
    push_frame(16'h0000);
    wait_frame();
    cycles(2);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
